mem_bus_arbiter: RTL

- Arbitrates the single data-memory port between two requesters: the CPU load/store path and the FPGA I/O block that deposits keypad operands and reads back results.
- Grants one requester at a time with round-robin fairness.
- Drives the shared memory port and waits for memory completion.
- Returns a one-cycle acknowledge, with read data, to the granted requester.
- Bounds every access with a timeout so a hung memory cannot stall the system.

---
 rtl/mem_bus_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU and the FPGA I/O block.
// One access per grant (IDLE -> ACC -> DONE); a hung memory is cut off after TIMEOUT wait cycles.
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              fpga_req,
    input  logic              fpga_wen,
    input  logic [ADDR_W-1:0] fpga_addr,
    input  logic [DATA_W-1:0] fpga_wdata,
    output logic [DATA_W-1:0] fpga_rdata,
    output logic              fpga_ack,
    output logic              err,
    output logic              mem_en,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        owner
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    // Encoding doubles as the owner output.
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        CPU_ACC  = 2'b01,
        FPGA_ACC = 2'b10,
        DONE     = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic              last_fpga_q, last_fpga_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wen_q, mem_wen_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              fpga_ack_q, fpga_ack_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] fpga_rdata_q, fpga_rdata_d;
    logic              finish;
    logic [DATA_W-1:0] resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_fpga_q  <= 1'b1;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_ack_q    <= 1'b0;
            fpga_ack_q   <= 1'b0;
            err_q        <= 1'b0;
            cpu_rdata_q  <= '0;
            fpga_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_fpga_q  <= last_fpga_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_wen_q    <= mem_wen_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_ack_q    <= cpu_ack_d;
            fpga_ack_q   <= fpga_ack_d;
            err_q        <= err_d;
            cpu_rdata_q  <= cpu_rdata_d;
            fpga_rdata_q <= fpga_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_fpga_d  = last_fpga_q;
        cnt_d        = cnt_q;
        mem_en_d     = mem_en_q;
        mem_wen_d    = mem_wen_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_ack_d    = 1'b0;
        fpga_ack_d   = 1'b0;
        err_d        = 1'b0;
        cpu_rdata_d  = cpu_rdata_q;
        fpga_rdata_d = fpga_rdata_q;
        finish       = 1'b0;
        resp         = '0;

        case (state_q)
            IDLE: begin
                // On a tie the requester not served last wins.
                if (cpu_req && (!fpga_req || last_fpga_q)) begin
                    state_d     = CPU_ACC;
                    last_fpga_d = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_wen_d   = cpu_wen;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    cnt_d       = '0;
                end else if (fpga_req) begin
                    state_d     = FPGA_ACC;
                    last_fpga_d = 1'b1;
                    mem_en_d    = 1'b1;
                    mem_wen_d   = fpga_wen;
                    mem_addr_d  = fpga_addr;
                    mem_wdata_d = fpga_wdata;
                    cnt_d       = '0;
                end
            end
            CPU_ACC, FPGA_ACC: begin
                if (mem_ready) begin
                    finish = 1'b1;
                    resp   = mem_wen_q ? '0 : mem_rdata;
                end else if (cnt_q == CNT_LIMIT) begin
                    finish = 1'b1;
                    err_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (finish) begin
                    state_d  = DONE;
                    mem_en_d = 1'b0;
                    if (state_q == CPU_ACC) begin
                        cpu_ack_d   = 1'b1;
                        cpu_rdata_d = resp;
                    end else begin
                        fpga_ack_d   = 1'b1;
                        fpga_rdata_d = resp;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign owner      = state_q;
    assign mem_en     = mem_en_q;
    assign mem_wen    = mem_wen_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign fpga_ack   = fpga_ack_q;
    assign err        = err_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign fpga_rdata = fpga_rdata_q;

endmodule
